// File: rtl/sa_pool_pkg.sv
// ============================================================================
//  Module  : sa_pool_pkg
//  Brief   : Shared FSM encodings, defaults and signed-max helper for the
//            2x2 max-pooling stage.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package sa_pool_pkg;

  localparam int MAX_W_DEF = 32;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_EVEN = 3'd1;
  localparam logic [2:0] ST_ODD  = 3'd2;
  localparam logic [2:0] ST_DROP = 3'd3;
  localparam logic [2:0] ST_BYP  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  // Operands are sign-extended to this width so one helper serves any DW <= 64.
  localparam int CMP_W = 128;

  function automatic logic signed [CMP_W-1:0] smax(input logic signed [CMP_W-1:0] a,
                                                   input logic signed [CMP_W-1:0] b);
    return (a >= b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pool_line_buffer.sv
// ============================================================================
//  Module  : pool_line_buffer
//  Brief   : One-row store of horizontal pair maxima; single write port,
//            asynchronous read port.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pool_line_buffer #(
  parameter int DEPTH = 16,
  parameter int SW    = 64,
  parameter int IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic signed [SW-1:0] wr_data,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic signed [SW-1:0] rd_data
);

  // No reset: every entry is written on the even row before the odd row reads it.
  logic signed [SW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_idx];

endmodule

`default_nettype wire

// File: rtl/max_pool_2x2.sv
// ============================================================================
//  Module  : max_pool_2x2
//  Brief   : Streaming 2x2 stride-2 signed max pooling with per-layer bypass.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module max_pool_2x2
  import sa_pool_pkg::*;
#(
  parameter int DW    = 32,
  parameter int MAX_W = MAX_W_DEF,
  parameter int SZ_W  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pool_en,
  input  logic [SZ_W-1:0]        fm_width,
  input  logic [SZ_W-1:0]        fm_height,
  input  logic                   data_valid,
  input  logic signed [2*DW-1:0] data_in,
  output logic signed [2*DW-1:0] data_out,
  output logic                   out_flag_pooling,
  output logic                   busy,
  output logic                   pool_done
);

  localparam int SW    = 2 * DW;
  localparam int DEPTH = MAX_W / 2;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]           r_state;
  logic [SZ_W-1:0]      r_col;
  logic [SZ_W-1:0]      r_row;
  logic [SZ_W-1:0]      r_width;
  logic [SZ_W-1:0]      r_height;
  logic signed [SW-1:0] r_pair;
  logic signed [SW-1:0] r_data_out;
  logic                 r_flag;

  logic                 w_accept;
  logic                 w_last_col;
  logic                 w_last_row;
  logic                 w_pre_last_row;
  logic                 w_lbuf_we;
  logic                 w_emit_pool;
  logic [IDX_W-1:0]     w_idx;
  logic signed [SW-1:0] w_pair_max;
  logic signed [SW-1:0] w_lbuf_rd;
  logic signed [SW-1:0] w_pool_max;

  assign w_accept = data_valid && ((r_state == ST_EVEN) || (r_state == ST_ODD) ||
                                   (r_state == ST_DROP) || (r_state == ST_BYP));

  assign w_last_col     = (r_col == r_width - SZ_W'(1));
  assign w_last_row     = (r_row == r_height - SZ_W'(1));
  assign w_pre_last_row = (r_row == r_height - SZ_W'(2));

  // Odd columns close a horizontal pair; a trailing even column of an odd width is dropped.
  assign w_lbuf_we   = w_accept && (r_state == ST_EVEN) && r_col[0];
  assign w_emit_pool = w_accept && (r_state == ST_ODD) && r_col[0];
  assign w_idx       = IDX_W'(r_col >> 1);

  assign w_pair_max = SW'(smax(CMP_W'(r_pair), CMP_W'(data_in)));
  assign w_pool_max = SW'(smax(CMP_W'(w_lbuf_rd), CMP_W'(w_pair_max)));

  pool_line_buffer #(
    .DEPTH (DEPTH),
    .SW    (SW),
    .IDX_W (IDX_W)
  ) u_lbuf (
    .clk     (clk),
    .wr_en   (w_lbuf_we),
    .wr_idx  (w_idx),
    .wr_data (w_pair_max),
    .rd_idx  (w_idx),
    .rd_data (w_lbuf_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_col      <= '0;
      r_row      <= '0;
      r_width    <= '0;
      r_height   <= '0;
      r_pair     <= '0;
      r_data_out <= '0;
      r_flag     <= 1'b0;
    end else begin
      r_flag     <= 1'b0;
      r_data_out <= '0;
      if (w_emit_pool) begin
        r_flag     <= 1'b1;
        r_data_out <= w_pool_max;
      end else if (w_accept && (r_state == ST_BYP)) begin
        r_flag     <= 1'b1;
        r_data_out <= data_in;
      end

      if (w_accept && !r_col[0]) begin
        r_pair <= data_in;
      end

      if (w_accept) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= r_row + SZ_W'(1);
        end else begin
          r_col <= r_col + SZ_W'(1);
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_width  <= fm_width;
            r_height <= fm_height;
            r_col    <= '0;
            r_row    <= '0;
            r_state  <= pool_en ? ST_EVEN : ST_BYP;
          end
        end
        ST_EVEN: begin
          if (w_accept && w_last_col) r_state <= ST_ODD;
        end
        ST_ODD: begin
          if (w_accept && w_last_col) begin
            if (w_last_row)                        r_state <= ST_DONE;
            else if (w_pre_last_row && r_height[0]) r_state <= ST_DROP;
            else                                   r_state <= ST_EVEN;
          end
        end
        ST_DROP: begin
          if (w_accept && w_last_col) r_state <= ST_DONE;
        end
        ST_BYP: begin
          if (w_accept && w_last_col && w_last_row) r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign data_out         = r_data_out;
  assign out_flag_pooling = r_flag;
  assign busy             = (r_state != ST_IDLE);
  assign pool_done        = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_max_pool_2x2.sv
// ============================================================================
//  Module  : tb_max_pool_2x2
//  Brief   : Directed self-checking bench for max_pool_2x2.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_max_pool_2x2;

  localparam int SW = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 pool_en;
  logic [5:0]           fm_width;
  logic [5:0]           fm_height;
  logic                 data_valid;
  logic signed [SW-1:0] data_in;
  logic signed [SW-1:0] data_out;
  logic                 out_flag_pooling;
  logic                 busy;
  logic                 pool_done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int zero_viol = 0;
  logic signed [SW-1:0] cap_q [$];

  always #5 clk = ~clk;

  max_pool_2x2 dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .pool_en          (pool_en),
    .fm_width         (fm_width),
    .fm_height        (fm_height),
    .data_valid       (data_valid),
    .data_in          (data_in),
    .data_out         (data_out),
    .out_flag_pooling (out_flag_pooling),
    .busy             (busy),
    .pool_done        (pool_done)
  );

  always @(negedge clk) begin
    if (out_flag_pooling) cap_q.push_back(data_out);
    else if (data_out !== '0) zero_viol++;
    if (pool_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic en, input logic [5:0] w, input logic [5:0] h);
    @(negedge clk);
    start = 1'b1; pool_en = en; fm_width = w; fm_height = h;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic signed [SW-1:0] v);
    data_valid = 1'b1; data_in = v;
    @(negedge clk);
    data_valid = 1'b0; data_in = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic clear_capture();
    cap_q.delete();
    done_cnt = 0;
  endtask

  initial begin
    logic signed [SW-1:0] exp4 [4];
    exp4[0] = 5; exp4[1] = 7; exp4[2] = 13; exp4[3] = 15;

    rst = 1'b1; start = 1'b0; pool_en = 1'b0; fm_width = '0; fm_height = '0;
    data_valid = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 64'd0);
    chk("rst_flag", {63'd0, out_flag_pooling}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, pool_done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 4x4 pooled ramp
    clear_capture();
    start_frame(1'b1, 6'd4, 6'd4);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    for (int i = 0; i < 16; i++) send(SW'(i));
    chk("t1_done_pulse", {63'd0, pool_done}, 64'd1);
    wait_idle();
    chk("t1_count", 64'(cap_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_out%0d", i), cap_q[i], exp4[i]);
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);

    // 2x2 all-negative: signed compare
    clear_capture();
    start_frame(1'b1, 6'd2, 6'd2);
    send(-64'sd8); send(-64'sd3); send(-64'sd5); send(-64'sd9);
    wait_idle();
    chk("t2_count", 64'(cap_q.size()), 64'd1);
    chk("t2_out", cap_q[0], 64'hFFFF_FFFF_FFFF_FFFD);

    // 5x3: odd width and odd height trimmed
    clear_capture();
    start_frame(1'b1, 6'd5, 6'd3);
    for (int i = 0; i < 14; i++) send(SW'(i));
    chk("t3_not_done_early", {63'd0, pool_done}, 64'd0);
    send(SW'(14));
    chk("t3_done_pulse", {63'd0, pool_done}, 64'd1);
    wait_idle();
    chk("t3_count", 64'(cap_q.size()), 64'd2);
    chk("t3_out0", cap_q[0], 64'd6);
    chk("t3_out1", cap_q[1], 64'd8);

    // 3x2 bypass with idle gaps, latency 1
    clear_capture();
    start_frame(1'b0, 6'd3, 6'd2);
    for (int i = 1; i <= 6; i++) begin
      send(SW'(i));
      chk($sformatf("t4_flag%0d", i), {63'd0, out_flag_pooling}, 64'd1);
      chk($sformatf("t4_data%0d", i), data_out, SW'(i));
      if (i == 6) chk("t4_done_pulse", {63'd0, pool_done}, 64'd1);
      @(negedge clk);
      chk($sformatf("t4_gap%0d", i), {63'd0, out_flag_pooling}, 64'd0);
    end
    wait_idle();
    chk("t4_count", 64'(cap_q.size()), 64'd6);

    // reset mid-frame, then a fresh frame must not see stale line-buffer data
    start_frame(1'b1, 6'd4, 6'd4);
    for (int i = 0; i < 6; i++) send(SW'(100 + i));
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_flag", {63'd0, out_flag_pooling}, 64'd0);
    chk("t5_rst_data", data_out, 64'd0);
    chk("t5_rst_busy", {63'd0, busy}, 64'd0);
    chk("t5_rst_done", {63'd0, pool_done}, 64'd0);
    rst = 1'b0;
    clear_capture();
    start_frame(1'b1, 6'd2, 6'd2);
    send(64'sd1); send(64'sd2); send(64'sd3); send(64'sd4);
    wait_idle();
    chk("t5_count", 64'(cap_q.size()), 64'd1);
    chk("t5_out", cap_q[0], 64'd4);

    // data_valid in IDLE ignored; start mid-frame ignored
    clear_capture();
    send(64'sd77); send(64'sd88);
    chk("t6_idle_busy", {63'd0, busy}, 64'd0);
    chk("t6_idle_count", 64'(cap_q.size()), 64'd0);
    start_frame(1'b1, 6'd2, 6'd2);
    send(64'sd10); send(64'sd20);
    start = 1'b1; pool_en = 1'b0; fm_width = 6'd3; fm_height = 6'd3;
    send(64'sd30);
    start = 1'b0;
    send(64'sd40);
    chk("t6_done_pulse", {63'd0, pool_done}, 64'd1);
    wait_idle();
    chk("t6_count", 64'(cap_q.size()), 64'd1);
    chk("t6_out", cap_q[0], 64'd40);
    chk("t6_done_cnt", 64'(done_cnt), 64'd1);

    chk("zero_when_invalid", 64'(zero_viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
